// File: rtl/sha256_pkg.sv
// Shared SHA-256 sequencing definitions: FSM encoding, bank addresses, IV.
package sha256_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned NUM_WORDS = 8;
  localparam int unsigned VEC_W     = WORD_W * NUM_WORDS;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned RIDX_W    = 6;
  localparam int unsigned LIDX_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_ACCUM = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_PASS = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_A    = 4'd1;
  localparam logic [ADDR_W-1:0] ADDR_B    = 4'd2;
  localparam logic [ADDR_W-1:0] ADDR_C    = 4'd3;
  localparam logic [ADDR_W-1:0] ADDR_D    = 4'd4;
  localparam logic [ADDR_W-1:0] ADDR_E    = 4'd5;
  localparam logic [ADDR_W-1:0] ADDR_F    = 4'd6;
  localparam logic [ADDR_W-1:0] ADDR_G    = 4'd7;
  localparam logic [ADDR_W-1:0] ADDR_H    = 4'd8;

  // Standard initial hash value, H0 in the top word
  localparam logic [VEC_W-1:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Pick word idx out of a packed 8-word vector, word 0 in the top bits
  function automatic logic [WORD_W-1:0] word_sel(input logic [VEC_W-1:0] vec,
                                                 input logic [LIDX_W-1:0] idx);
    logic [VEC_W-1:0] sh;
    sh = vec << (WORD_W * 32'(idx));
    return sh[VEC_W-1 -: WORD_W];
  endfunction

endpackage

// File: rtl/sha256_round_sequencer_if.sv
// Feeder / bank-side signal bundle of the round sequencer.
interface sha256_round_sequencer_if;
  logic                               msg_valid;
  logic                               msg_first;
  logic                               msg_ready;
  logic [sha256_pkg::VEC_W-1:0]       work_in;
  logic [sha256_pkg::VEC_W-1:0]       hash_in;
  logic [sha256_pkg::ADDR_W-1:0]      bank_addr;
  logic [sha256_pkg::WORD_W-1:0]      bank_data;
  logic                               round_en;
  logic [sha256_pkg::RIDX_W-1:0]      round_idx;
  logic                               busy;
  logic                               done;
  logic [sha256_pkg::VEC_W-1:0]       digest;

  modport master (
    output msg_valid, msg_first, work_in, hash_in,
    input  msg_ready, bank_addr, bank_data, round_en, round_idx, busy, done, digest
  );

  modport slave (
    input  msg_valid, msg_first, work_in, hash_in,
    output msg_ready, bank_addr, bank_data, round_en, round_idx, busy, done, digest
  );
endinterface

// File: rtl/sha256_digest_acc.sv
// Running digest H0..H7: seeded word by word during LOAD, folded with A..H in ACCUM.
module sha256_digest_acc
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [LIDX_W-1:0] load_idx,
  input  logic [WORD_W-1:0] load_data,
  input  logic              acc_en,
  input  logic [VEC_W-1:0]  work_in,
  output logic [VEC_W-1:0]  h
);

  // Per-word modulo-2^32 add; carries stay inside each word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
    end else if (acc_en) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        h[WORD_W*i +: WORD_W] <= h[WORD_W*i +: WORD_W] + work_in[WORD_W*i +: WORD_W];
      end
    end else if (load_en) begin
      h[WORD_W*(NUM_WORDS-1-32'(load_idx)) +: WORD_W] <= load_data;
    end
  end

endmodule

// File: rtl/sha256_round_sequencer.sv
// SHA-256 compression sequencer: load A..H, step 64 rounds, optionally fold digest.
// Optional feature macro: SHA256_DIGEST_ACC_EN (internal digest accumulator).
module sha256_round_sequencer
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS   = 64,
  parameter int unsigned NUM_VARS = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  sha256_round_sequencer_if.slave    bus
);

  state_e              state;
  logic                first_q;
  logic [LIDX_W-1:0]   load_idx;
  logic                msg_ready_q;
  logic [ADDR_W-1:0]   bank_addr_q;
  logic [WORD_W-1:0]   bank_data_q;
  logic                round_en_q;
  logic [RIDX_W-1:0]   round_idx_q;
  logic                busy_q;
  logic                done_q;
  logic [VEC_W-1:0]    chain_src;
  logic [LIDX_W-1:0]   load_nxt;

  assign load_nxt = load_idx + LIDX_W'(1);

`ifdef SHA256_DIGEST_ACC_EN
  logic [VEC_W-1:0] h_q;
  logic             h_load_en;
  logic             h_acc_en;
  logic             unused_hash_in;

  // IV words go into H alongside the bank write they accompany
  assign h_load_en = (state == ST_LOAD) && first_q;
  assign h_acc_en  = (state == ST_ACCUM);

  sha256_digest_acc u_digest_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (h_load_en),
    .load_idx  (load_idx),
    .load_data (bank_data_q),
    .acc_en    (h_acc_en),
    .work_in   (bus.work_in),
    .h         (h_q)
  );

  assign chain_src      = h_q;
  assign bus.digest     = h_q;
  assign unused_hash_in = ^bus.hash_in;
`else
  logic unused_work_in;

  assign chain_src      = bus.hash_in;
  assign bus.digest     = '0;
  assign unused_work_in = ^bus.work_in;
`endif

  assign bus.msg_ready = msg_ready_q;
  assign bus.bank_addr = bank_addr_q;
  assign bus.bank_data = bank_data_q;
  assign bus.round_en  = round_en_q;
  assign bus.round_idx = round_idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  // Block FSM; outputs are registered alongside the state they belong to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      first_q     <= 1'b0;
      load_idx    <= '0;
      msg_ready_q <= 1'b1;
      bank_addr_q <= ADDR_PASS;
      bank_data_q <= '0;
      round_en_q  <= 1'b0;
      round_idx_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.msg_valid) begin
            state       <= ST_LOAD;
            first_q     <= bus.msg_first;
            load_idx    <= '0;
            msg_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            bank_addr_q <= ADDR_A;
            bank_data_q <= bus.msg_first ? word_sel(IV, '0) : word_sel(chain_src, '0);
          end
        end
        ST_LOAD: begin
          if (load_idx == LIDX_W'(NUM_VARS - 1)) begin
            state       <= ST_ROUND;
            bank_addr_q <= ADDR_PASS;
            bank_data_q <= '0;
            round_en_q  <= 1'b1;
            round_idx_q <= '0;
          end else begin
            load_idx    <= load_nxt;
            bank_addr_q <= bank_addr_q + ADDR_W'(1);
            bank_data_q <= first_q ? word_sel(IV, load_nxt) : word_sel(chain_src, load_nxt);
          end
        end
        ST_ROUND: begin
          if (round_idx_q == RIDX_W'(ROUNDS - 1)) begin
            round_en_q  <= 1'b0;
            round_idx_q <= '0;
`ifdef SHA256_DIGEST_ACC_EN
            state       <= ST_ACCUM;
`else
            state       <= ST_DONE;
            done_q      <= 1'b1;
`endif
          end else begin
            round_idx_q <= round_idx_q + RIDX_W'(1);
          end
        end
`ifdef SHA256_DIGEST_ACC_EN
        ST_ACCUM: begin
          state  <= ST_DONE;
          done_q <= 1'b1;
        end
`endif
        ST_DONE: begin
          state       <= ST_IDLE;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          msg_ready_q <= 1'b1;
        end
        default: begin
          state       <= ST_IDLE;
          msg_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          round_en_q  <= 1'b0;
          bank_addr_q <= ADDR_PASS;
        end
      endcase
    end
  end

endmodule
